// File: rtl/gcd_controller.sv
// gcd_controller: Moore FSM sequencing a subtract-and-compare datapath to compute GCD(A,B)
// Ports: clk, reset (async, active-high), start (sampled in IDLE), N/Z (datapath flags, A<B / A==B);
//        ab_sel, ABorALU, LDA, LDB, FN drive the datapath; busy/done/err form the handshake.
// Optional: define GCD_TIMEOUT_EN to add an ITER_W-bit subtraction counter and the ERR state.
module gcd_controller #(
  parameter logic [1:0] FN_AMB   = 2'b00,
  parameter logic [1:0] FN_BMA   = 2'b01,
  parameter logic [1:0] FN_PASSA = 2'b10,
  parameter int         ITER_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       N,
  input  logic       Z,
  output logic       ab_sel,
  output logic       ABorALU,
  output logic       LDA,
  output logic       LDB,
  output logic [1:0] FN,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE, ERR} state_t;
  state_t state, next;
  logic timeout;
`ifdef GCD_TIMEOUT_EN
  logic [ITER_W-1:0] iter;
  always_ff @(posedge clk or posedge reset)
    if (reset) iter <= '0;
    else if (state == LOAD_A) iter <= '0;
    else if (state == SUB_A || state == SUB_B) iter <= iter + 1'b1;
  // a saturated counter means 2^ITER_W-1 subtractions already happened without convergence
  assign timeout = &iter;
  assign err = state == ERR;
`else
  logic [ITER_W-1:0] iter_unused;
  assign iter_unused = '0;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:         next = start ? LOAD_A : IDLE;
      LOAD_A:       next = LOAD_B;
      LOAD_B:       next = CMP;
      CMP:          next = Z ? DONE : timeout ? ERR : N ? SUB_B : SUB_A;
      SUB_A, SUB_B: next = CMP;
      DONE, ERR:    next = start ? state : IDLE;
      default:      next = IDLE;
    endcase
  end
  assign ab_sel  = state == LOAD_B;
  assign ABorALU = state == IDLE || state == LOAD_A || state == LOAD_B;
  assign LDA     = state == LOAD_A || state == SUB_A;
  assign LDB     = state == LOAD_B || state == SUB_B;
  // flags are only meaningful under A-B, so CMP (and the loads) keep FN_AMB
  assign FN      = state == SUB_B ? FN_BMA : (state == DONE || state == ERR) ? FN_PASSA : FN_AMB;
  assign busy    = state == LOAD_A || state == LOAD_B || state == CMP || state == SUB_A || state == SUB_B;
  assign done    = state == DONE || state == ERR;
endmodule
